// File: rtl/uart_pkg.sv
// Shared UART constants: data width, transmit FSM encoding and baud timing.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // sys_clk cycles per bit, truncated; shared so transmit and receive agree.
    function automatic int bps_cnt(input int clk_freq, input int bps);
        return clk_freq / bps;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO holding bytes waiting to be serialised.
// Read data is shown at the head (first-word fall-through).
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [UART_DATA_W-1:0]   din,
    output logic [UART_DATA_W-1:0]   dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [UART_DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]          wr_ptr_r;
    logic [AW-1:0]          rd_ptr_r;
    logic [CW-1:0]          count_r;
    logic                   push_ok_s;
    logic                   pop_ok_s;

    // Full/empty decode straight from the registered occupancy.
    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign dout      = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage write; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_send.sv
// UART 8N1 transmitter: queues bytes from the core and serialises them
// LSB first, chaining frames without an idle gap while bytes are waiting.
module uart_send
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 10_000_000,
    parameter int UART_BPS   = 38400,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic [UART_DATA_W-1:0]        tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uart_txd,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int          BPS_CNT = bps_cnt(CLK_FREQ, UART_BPS);
    localparam logic [15:0] LAST    = 16'(BPS_CNT - 1);

    if (BPS_CNT < 1 || BPS_CNT > 65535) begin : g_bps_chk
        $error("uart_send: BPS_CNT out of 1..65535");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
        $error("uart_send: FIFO_DEPTH must be a power of 2 and at least 2");
    end

    uart_state_e            state_r, state_s;
    logic [15:0]            clk_cnt_r, clk_cnt_s;
    logic [2:0]             bit_idx_r, bit_idx_s;
    logic [2:0]             bit_nxt_s;
    logic [UART_DATA_W-1:0] shift_r, shift_s;
    logic                   txd_r, txd_s;
    logic                   done_r, done_s;
    logic                   busy_r;
    logic                   pop_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic [UART_DATA_W-1:0] fifo_dout_s;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .push  (tx_valid),
        .pop   (pop_s),
        .din   (tx_data),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count)
    );

    assign tx_ready  = ~fifo_full_s;
    assign uart_txd  = txd_r;
    assign tx_done   = done_r;
    assign tx_busy   = busy_r;
    assign bit_nxt_s = bit_idx_r + 3'd1;

    // Next-state, baud counter, shift load and line level for the coming cycle.
    always_comb begin
        state_s   = state_r;
        clk_cnt_s = clk_cnt_r;
        bit_idx_s = bit_idx_r;
        shift_s   = shift_r;
        txd_s     = txd_r;
        pop_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s     = 1'b1;
                    shift_s   = fifo_dout_s;
                    clk_cnt_s = 16'd0;
                    state_s   = START;
                    txd_s     = 1'b0;
                end else begin
                    txd_s     = 1'b1;
                end
            end
            START: begin
                if (clk_cnt_r == LAST) begin
                    clk_cnt_s = 16'd0;
                    bit_idx_s = 3'd0;
                    state_s   = DATA;
                    txd_s     = shift_r[0];
                end else begin
                    clk_cnt_s = clk_cnt_r + 16'd1;
                    txd_s     = 1'b0;
                end
            end
            DATA: begin
                if (clk_cnt_r == LAST) begin
                    clk_cnt_s = 16'd0;
                    if (bit_idx_r == 3'd7) begin
                        state_s = STOP;
                        txd_s   = 1'b1;
                    end else begin
                        bit_idx_s = bit_nxt_s;
                        txd_s     = shift_r[bit_nxt_s];
                    end
                end else begin
                    clk_cnt_s = clk_cnt_r + 16'd1;
                    txd_s     = shift_r[bit_idx_r];
                end
            end
            STOP: begin
                if (clk_cnt_r == LAST) begin
                    clk_cnt_s = 16'd0;
                    if (!fifo_empty_s) begin
                        // Chain straight into the next start bit.
                        pop_s   = 1'b1;
                        shift_s = fifo_dout_s;
                        state_s = START;
                        txd_s   = 1'b0;
                    end else begin
                        state_s = IDLE;
                        txd_s   = 1'b1;
                    end
                end else begin
                    clk_cnt_s = clk_cnt_r + 16'd1;
                    txd_s     = 1'b1;
                end
            end
            default: begin
                state_s   = IDLE;
                clk_cnt_s = 16'd0;
                txd_s     = 1'b1;
            end
        endcase
        done_s = (state_s == STOP) && (clk_cnt_s == LAST);
    end

    // State and datapath registers; reset abandons any frame and idles the line.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r   <= IDLE;
            clk_cnt_r <= 16'd0;
            bit_idx_r <= 3'd0;
            shift_r   <= {UART_DATA_W{1'b0}};
            txd_r     <= 1'b1;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            clk_cnt_r <= clk_cnt_s;
            bit_idx_r <= bit_idx_s;
            shift_r   <= shift_s;
            txd_r     <= txd_s;
            done_r    <= done_s;
            busy_r    <= (state_s != IDLE);
        end
    end

endmodule
